alu_seq_param: RTL and testbench

//  Parametrised, handshaked successor of the 16-bit ALU. Accepts one operation per
//  IN_VALID/IN_READY transfer, returns a registered result with one-cycle OUT_VALID.

---
 rtl/alu_seq_param_if.sv | 31 +++
 rtl/alu_seq_param.sv | 205 ++++++++++++++++++++
 tb/tb_alu_seq_param.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_param_if.sv
// rtl/alu_seq_param_if.sv - request/result bundle between sequencer, alu_seq_param and write-back
interface alu_seq_param_if #(
    parameter int WIDTH = 16,
    parameter int FUN_W = 4
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [FUN_W-1:0] ALU_FUN;
    logic             OUT_VALID;
    logic [WIDTH-1:0] ALU_OUT;
    logic             Carry_Flag;
    logic             Arith_Flag;
    logic             Logic_Flag;
    logic             CMP_Flag;
    logic             Shift_Flag;
    logic             Div_Zero;

    modport master (
        output IN_VALID, A, B, ALU_FUN,
        input  IN_READY, OUT_VALID, ALU_OUT,
        input  Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag, Div_Zero
    );

    modport slave (
        input  IN_VALID, A, B, ALU_FUN,
        output IN_READY, OUT_VALID, ALU_OUT,
        output Carry_Flag, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag, Div_Zero
    );
endinterface

// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - handshaked ALU, 1-cycle ops plus restoring divider when ALU_DIV_EN is defined
module alu_seq_param #(
    parameter int WIDTH = 16,
    parameter int FUN_W = 4
) (
    input  logic           CLK,
    input  logic           RST,
    alu_seq_param_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [FUN_W-1:0] OP_ADD  = FUN_W'(0);
    localparam logic [FUN_W-1:0] OP_SUB  = FUN_W'(1);
    localparam logic [FUN_W-1:0] OP_MUL  = FUN_W'(2);
    localparam logic [FUN_W-1:0] OP_DIV  = FUN_W'(3);
    localparam logic [FUN_W-1:0] OP_AND  = FUN_W'(4);
    localparam logic [FUN_W-1:0] OP_OR   = FUN_W'(5);
    localparam logic [FUN_W-1:0] OP_NAND = FUN_W'(6);
    localparam logic [FUN_W-1:0] OP_NOR  = FUN_W'(7);
    localparam logic [FUN_W-1:0] OP_XOR  = FUN_W'(8);
    localparam logic [FUN_W-1:0] OP_XNOR = FUN_W'(9);
    localparam logic [FUN_W-1:0] OP_EQ   = FUN_W'(10);
    localparam logic [FUN_W-1:0] OP_GT   = FUN_W'(11);
    localparam logic [FUN_W-1:0] OP_LT   = FUN_W'(12);
    localparam logic [FUN_W-1:0] OP_SHR  = FUN_W'(13);
    localparam logic [FUN_W-1:0] OP_SHL  = FUN_W'(14);

    // Class flag vector order: {arith, logic, cmp, shift}
    localparam logic [3:0] CLS_ARITH = 4'b1000;
    localparam logic [3:0] CLS_LOGIC = 4'b0100;
    localparam logic [3:0] CLS_CMP   = 4'b0010;
    localparam logic [3:0] CLS_SHIFT = 4'b0001;

`ifdef ALU_DIV_EN
    typedef enum logic [1:0] {S_INIT, S_IDLE, S_DIV} state_t;
`else
    typedef enum logic [1:0] {S_INIT, S_IDLE} state_t;
`endif

    state_t             state_q, state_d;
    logic               in_ready;
    logic               accept;
    logic               div_start;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [FUN_W-1:0]   fun_q;
    logic               pend_q;

    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_d;
    logic               carry_d, dz_d;
    logic [3:0]         cls_d;

    logic               out_valid_q;
    logic [WIDTH-1:0]   out_q;
    logic               carry_q, dz_q;
    logic [3:0]         cls_q;

`ifdef ALU_DIV_EN
    logic [WIDTH-1:0]   quo_q, rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     trial;
`endif

    // S_INIT keeps IN_READY low until the first edge after reset release
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= S_INIT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            S_INIT: state_d = S_IDLE;
            S_IDLE: begin
                in_ready = 1'b1;
`ifdef ALU_DIV_EN
                if (div_start) state_d = S_DIV;
`endif
            end
`ifdef ALU_DIV_EN
            S_DIV: if (cnt_q == CNT_W'(WIDTH)) state_d = S_IDLE;
`endif
            default: state_d = S_INIT;
        endcase
    end

    assign accept = bus.IN_VALID & (state_q == S_IDLE);

`ifdef ALU_DIV_EN
    assign div_start = accept && (bus.ALU_FUN == OP_DIV) && (bus.B != '0);
`else
    assign div_start = 1'b0;
`endif

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        prod    = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        res_d   = '0;
        carry_d = 1'b0;
        cls_d   = 4'b0000;
        dz_d    = 1'b0;
        case (fun_q)
            OP_ADD:  begin res_d = sum[WIDTH-1:0];   carry_d = sum[WIDTH];              cls_d = CLS_ARITH; end
            OP_SUB:  begin res_d = diff[WIDTH-1:0];  carry_d = diff[WIDTH];             cls_d = CLS_ARITH; end
            OP_MUL:  begin res_d = prod[WIDTH-1:0];  carry_d = |prod[2*WIDTH-1:WIDTH];  cls_d = CLS_ARITH; end
            OP_DIV:  begin
                cls_d = CLS_ARITH;
`ifdef ALU_DIV_EN
                // Only zero divisors reach the single-cycle path
                res_d = '1;
                dz_d  = 1'b1;
`endif
            end
            OP_AND:  begin res_d = a_q & b_q;    cls_d = CLS_LOGIC; end
            OP_OR:   begin res_d = a_q | b_q;    cls_d = CLS_LOGIC; end
            OP_NAND: begin res_d = ~(a_q & b_q); cls_d = CLS_LOGIC; end
            OP_NOR:  begin res_d = ~(a_q | b_q); cls_d = CLS_LOGIC; end
            OP_XOR:  begin res_d = a_q ^ b_q;    cls_d = CLS_LOGIC; end
            OP_XNOR: begin res_d = ~(a_q ^ b_q); cls_d = CLS_LOGIC; end
            OP_EQ:   begin res_d = (a_q == b_q) ? WIDTH'(1) : '0; cls_d = CLS_CMP; end
            OP_GT:   begin res_d = (a_q > b_q)  ? WIDTH'(2) : '0; cls_d = CLS_CMP; end
            OP_LT:   begin res_d = (a_q < b_q)  ? WIDTH'(3) : '0; cls_d = CLS_CMP; end
            OP_SHR:  begin res_d = a_q >> 1; carry_d = a_q[0];       cls_d = CLS_SHIFT; end
            OP_SHL:  begin res_d = a_q << 1; carry_d = a_q[WIDTH-1]; cls_d = CLS_SHIFT; end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= '0;
            pend_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            carry_q     <= 1'b0;
            cls_q       <= 4'b0000;
            dz_q        <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            pend_q      <= accept & ~div_start;
            if (accept) begin
                a_q   <= bus.A;
                b_q   <= bus.B;
                fun_q <= bus.ALU_FUN;
            end
            if (pend_q) begin
                out_valid_q <= 1'b1;
                out_q       <= res_d;
                carry_q     <= carry_d;
                cls_q       <= cls_d;
                dz_q        <= dz_d;
            end
`ifdef ALU_DIV_EN
            if (state_q == S_DIV && cnt_q == CNT_W'(WIDTH)) begin
                out_valid_q <= 1'b1;
                out_q       <= quo_q;
                carry_q     <= 1'b0;
                cls_q       <= CLS_ARITH;
                dz_q        <= 1'b0;
            end
`endif
        end
    end

`ifdef ALU_DIV_EN
    // Restoring step: shift next dividend bit into the remainder, subtract divisor if it fits
    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, b_q};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            quo_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else if (div_start) begin
            quo_q <= bus.A;
            rem_q <= '0;
            cnt_q <= '0;
        end else if (state_q == S_DIV && cnt_q != CNT_W'(WIDTH)) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (!trial[WIDTH]) begin
                rem_q <= trial[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end
`endif

    assign bus.IN_READY   = in_ready;
    assign bus.OUT_VALID  = out_valid_q;
    assign bus.ALU_OUT    = out_q;
    assign bus.Carry_Flag = carry_q;
    assign bus.Arith_Flag = cls_q[3];
    assign bus.Logic_Flag = cls_q[2];
    assign bus.CMP_Flag   = cls_q[1];
    assign bus.Shift_Flag = cls_q[0];
    assign bus.Div_Zero   = dz_q;
endmodule

// File: tb/tb_alu_seq_param.sv
// tb/tb_alu_seq_param.sv - randomized scoreboard bench for alu_seq_param (follows ALU_DIV_EN)
module tb_alu_seq_param;
    localparam int W = 16;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    alu_seq_param_if #(.WIDTH(W), .FUN_W(4)) bus ();
    alu_seq_param #(.WIDTH(W), .FUN_W(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));

`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    // flags order: {carry, arith, logic, cmp, shift, div_zero}
    typedef struct {
        int           due;
        logic [W-1:0] res;
        logic [5:0]   flags;
    } exp_t;

    exp_t         exp_q[$];
    int           n_checks = 0;
    int           n_pass = 0;
    int           cyc = 0;
    int           ready_start = 0;
    int           busy_end = -1;
    logic [W-1:0] last_res = '0;
    logic [5:0]   last_flags = '0;
    logic [5:0]   dut_flags;

    assign dut_flags = {bus.Carry_Flag, bus.Arith_Flag, bus.Logic_Flag,
                        bus.CMP_Flag, bus.Shift_Flag, bus.Div_Zero};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] f, input int now);
        longint ua, ub, m, r;
        bit c, ar, lg, cm, sh, dz;
        exp_t e;
        ua = longint'(a); ub = longint'(b); m = longint'(1) << W; r = 0;
        c = 0; ar = 0; lg = 0; cm = 0; sh = 0; dz = 0;
        e.due = now + 1;
        case (f)
            4'd0:  begin r = ua + ub; c = (r >= m); ar = 1; end
            4'd1:  begin r = ua - ub; c = (ua < ub); ar = 1; end
            4'd2:  begin r = ua * ub; c = (r >= m); ar = 1; end
            4'd3:  begin
                ar = 1;
                if (!DIV_EN) r = 0;
                else if (ub == 0) begin r = m - 1; dz = 1; end
                else begin r = ua / ub; e.due = now + W + 1; end
            end
            4'd4:  begin r = ua & ub; lg = 1; end
            4'd5:  begin r = ua | ub; lg = 1; end
            4'd6:  begin r = (m - 1) - (ua & ub); lg = 1; end
            4'd7:  begin r = (m - 1) - (ua | ub); lg = 1; end
            4'd8:  begin r = ua ^ ub; lg = 1; end
            4'd9:  begin r = (m - 1) - (ua ^ ub); lg = 1; end
            4'd10: begin r = (ua == ub) ? 1 : 0; cm = 1; end
            4'd11: begin r = (ua > ub) ? 2 : 0; cm = 1; end
            4'd12: begin r = (ua < ub) ? 3 : 0; cm = 1; end
            4'd13: begin r = ua / 2; c = (ua % 2 == 1); sh = 1; end
            4'd14: begin r = ua * 2; c = (ua >= m / 2); sh = 1; end
            default: r = 0;
        endcase
        r = ((r % m) + m) % m;
        e.res   = W'(r);
        e.flags = {c, ar, lg, cm, sh, dz};
        return e;
    endfunction

    task automatic sample();
        bit rdy, ov;
        rdy = (cyc >= ready_start) && (cyc > busy_end);
        check("in_ready", bus.IN_READY, rdy);
        ov = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("out_valid", bus.OUT_VALID, ov);
        if (ov) begin
            last_res   = exp_q[0].res;
            last_flags = exp_q[0].flags;
            void'(exp_q.pop_front());
        end
        check("alu_out", bus.ALU_OUT, last_res);
        check("flags", dut_flags, last_flags);
    endtask

    // One clock: drive at the sample point, transfer on the rising edge, sample at the falling edge
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
        bit rdy;
        exp_t e;
        rdy = (cyc >= ready_start) && (cyc > busy_end);
        bus.IN_VALID = v; bus.A = a; bus.B = b; bus.ALU_FUN = f;
        @(posedge CLK);
        cyc++;
        if (v && rdy) begin
            e = model(a, b, f, cyc);
            exp_q.push_back(e);
            if (e.due > cyc + 1) busy_end = e.due - 1;
        end
        @(negedge CLK);
        sample();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 4'd0);
    endtask

    task automatic do_reset(input int hold);
        bus.IN_VALID = 1'b0;
        #2 RST = 1'b0;
        #1;
        check("rst_out_valid", bus.OUT_VALID, 0);
        check("rst_alu_out", bus.ALU_OUT, 0);
        check("rst_flags", dut_flags, 0);
        check("rst_in_ready", bus.IN_READY, 0);
        exp_q.delete();
        last_res = '0; last_flags = '0; busy_end = -1;
        for (int i = 0; i < hold; i++) begin @(posedge CLK); cyc++; end
        @(negedge CLK);
        #2 RST = 1'b1;
        ready_start = cyc + 1;
        #1 check("rel_in_ready", bus.IN_READY, 0);
        @(posedge CLK); cyc++;
        @(negedge CLK);
        sample();
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [3:0]   rf;
        bus.IN_VALID = 1'b0; bus.A = '0; bus.B = '0; bus.ALU_FUN = '0;
        RST = 1'b1;
        #1 RST = 1'b0;
        @(negedge CLK);
        do_reset(2);

        step(1'b1, 16'hFFFF, 16'h0001, 4'd0);
        idle(2);
        step(1'b1, 16'h0100, 16'h0100, 4'd2);
        step(1'b1, 16'hF0F0, 16'h0FF0, 4'd4);
        step(1'b1, 16'd5, 16'd3, 4'd11);
        idle(2);

        step(1'b1, 16'd1000, 16'd7, 4'd3);
        for (int i = 0; i < W + 2; i++) step(1'b1, 16'(i * 37), 16'(i + 1), 4'(i % 15));
        idle(3);
        step(1'b1, 16'd5, 16'd0, 4'd3);
        step(1'b1, 16'd9, 16'd4, 4'd1);
        idle(2);
        step(1'b1, 16'h8001, 16'h0000, 4'd13);
        step(1'b1, 16'h8001, 16'h0000, 4'd14);
        step(1'b1, 16'h1234, 16'h5678, 4'd15);
        idle(2);

        for (int i = 0; i < 700; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = '1;
                2:       rb = ra;
                default: rb = 16'($urandom);
            endcase
            rf = 4'($urandom_range(0, 15));
            step($urandom_range(0, 9) < 7, ra, rb, rf);
        end
        idle(W + 3);

        step(1'b1, 16'h1234, 16'h4321, 4'd0);
        step(1'b0, '0, '0, 4'd0);
        do_reset(1);

        step(1'b1, 16'd1000, 16'd7, 4'd3);
        idle(3);
        do_reset(1);
        idle(W + 6);
        step(1'b1, 16'd7, 16'd7, 4'd10);
        idle(2);

        check("drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
